// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  localparam int unsigned DefaultWordW  = 32;
  localparam int unsigned DefaultNWords = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mp_add_slice.sv
// Combinational WORD_W-bit adder slice: 4-bit lookahead groups, group carries chained.
module mp_add_slice
  import mp_add_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int NGrp = (WORD_W + 3) / 4;
  localparam int PadW = NGrp * 4;

  logic [PadW-1:0] a_pad, b_pad, p, g;
  logic [PadW:0]   c;
  logic [NGrp-1:0] grp_c;
  logic            run_g, run_p;

  always_comb begin
    a_pad             = '0;
    b_pad             = '0;
    a_pad[WORD_W-1:0] = a_i;
    b_pad[WORD_W-1:0] = b_i;
    p                 = a_pad ^ b_pad;
    g                 = a_pad & b_pad;
    c                 = '0;
    grp_c             = '0;
    run_g             = 1'b0;
    run_p             = 1'b1;
    grp_c[0]          = cin_i;
    for (int k = 0; k < NGrp; k++) begin
      run_g    = 1'b0;
      run_p    = 1'b1;
      c[4*k]   = grp_c[k];
      // Prefix generate/propagate within the group, each carry taken from the group carry-in.
      for (int j = 0; j < 4; j++) begin
        run_g        = g[4*k+j] | (p[4*k+j] & run_g);
        run_p        = p[4*k+j] & run_p;
        c[4*k+j+1]   = run_g | (run_p & grp_c[k]);
      end
      if (k + 1 < NGrp) begin
        grp_c[k+1] = run_g | (run_p & grp_c[k]);
      end
    end
  end

  assign sum_o  = p[WORD_W-1:0] ^ c[WORD_W-1:0];
  assign cout_o = c[WORD_W];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one adder slice reused over NWORDS cycles,
// carry chained through a register, result held until the consumer takes it.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW,
  parameter int unsigned NWORDS = DefaultNWords
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*WORD_W-1:0] in_a,
  input  logic [NWORDS*WORD_W-1:0] in_b,
  input  logic                     in_sub,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*WORD_W-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int unsigned      CntW    = $clog2(NWORDS);
  localparam logic [CntW-1:0]  LastCnt = CntW'(NWORDS - 1);

  typedef logic [NWORDS-1:0][WORD_W-1:0] words_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  words_t          a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            sub_q, sub_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [WORD_W-1:0] a_word, b_word, slice_sum;
  logic              slice_cout;

  assign a_word = a_q[cnt_q];
  assign b_word = sub_q ? ~b_q[cnt_q] : b_q[cnt_q];

  mp_add_slice #(
    .WORD_W(WORD_W)
  ) u_slice (
    .a_i   (a_word),
    .b_i   (b_word),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          // Subtraction is A + ~B + 1, so a borrow-in becomes a cleared carry-in.
          carry_d = in_sub ? ~in_cin : in_cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[cnt_q] = slice_sum;
        carry_d      = slice_cout;
        if (cnt_q == LastCnt) begin
          cout_d  = slice_cout;
          ovf_d   = (a_word[WORD_W-1] == b_word[WORD_W-1]) &
                    (slice_sum[WORD_W-1] != a_word[WORD_W-1]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed operations, a wide-arithmetic reference model checked
// every valid output cycle, and literal expectations for each directed case.
module tb_mp_add_seq;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 4;
  localparam int W = WORD_W * NWORDS;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_sub, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];

  mp_add_seq #(
    .WORD_W(WORD_W),
    .NWORDS(NWORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width unsigned arithmetic for sum/cout, sign-extended arithmetic for ovf.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         e;
    logic [W:0]   wide;
    logic [W+1:0] sa, sb, r;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    if (sub) begin
      e.sum  = a - b - W'(cin);
      e.cout = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
      r      = sa - sb - (W+2)'(cin);
    end else begin
      wide   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.sum  = wide[W-1:0];
      e.cout = wide[W];
      r      = sa + sb + (W+2)'(cin);
    end
    e.ovf = (r[W] != r[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Scoreboard: push on accept, compare every valid cycle, pop on handoff.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_out_valid");
        end else begin
          check("model_sum",  out_sum,  exp_q[0].sum);
          check("model_cout", W'(out_cout), W'(exp_q[0].cout));
          check("model_ovf",  W'(out_ovf),  W'(exp_q[0].ovf));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
    end
  end

  // Driver phase is always 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic cin, input bit hold);
    bit ok = 0;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) timeout("accept");
    if (!hold) in_valid = 1'b0;
  endtask

  // Counts edges including the accept edge until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) return;
    end
    timeout("out_valid");
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W-1:0] esum,
                        input logic ecout, input logic eovf);
    int edges;
    send(a, b, sub, cin, 1'b0);
    wait_done(edges);
    check({name, "_sum"},  out_sum, esum);
    check({name, "_cout"}, W'(out_cout), W'(ecout));
    check({name, "_ovf"},  W'(out_ovf),  W'(eovf));
    @(posedge clk); #1;
  endtask

  logic [W-1:0] ones, msb, max_pos, bp_a, bp_b, bp_sum;
  int           edges, t1, t2;

  initial begin
    ones    = '1;
    msb     = {1'b1, {(W-1){1'b0}}};
    max_pos = ~msb;
    bp_a    = 128'h0123456789ABCDEF_FEDCBA9876543210;
    bp_b    = 128'h1111111111111111_1111111111111111;
    bp_sum  = 128'h123456789ABCDF01_0FEDCBA987654321;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum",       out_sum,       '0);
    check("rst_cout",      W'(out_cout),  W'(0));
    check("rst_ovf",       W'(out_ovf),   W'(0));
    check("rst_busy",      W'(busy),      W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripple through every word, plus latency.
    send(ones, 128'd1, 1'b0, 1'b0, 1'b0);
    wait_done(edges);
    check("latency_edges", W'(edges), W'(NWORDS + 1));
    check("ripple_sum",  out_sum, '0);
    check("ripple_cout", W'(out_cout), W'(1));
    check("ripple_ovf",  W'(out_ovf),  W'(0));
    @(posedge clk); #1;

    run_op("sub_borrow", '0, 128'd1, 1'b1, 1'b0, ones, 1'b0, 1'b0);
    run_op("sub_ovf", msb, 128'd1, 1'b1, 1'b0, max_pos, 1'b1, 1'b1);
    run_op("add_cin", 128'd5, 128'd3, 1'b0, 1'b1, 128'd9, 1'b0, 1'b0);
    run_op("sub_bin", 128'd5, 128'd3, 1'b1, 1'b1, 128'd1, 1'b1, 1'b0);
    run_op("add_posovf", max_pos, 128'd1, 1'b0, 1'b0, msb, 1'b0, 1'b1);
    run_op("mid_carry", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
           128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);

    // Backpressure: result held, new request ignored until handoff.
    out_ready = 1'b0;
    send(bp_a, bp_b, 1'b0, 1'b0, 1'b0);
    wait_done(edges);
    in_a = 128'd100; in_b = 128'd1; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready",  W'(in_ready),  W'(0));
      check("bp_sum",       out_sum,       bp_sum);
    end
    out_ready = 1'b1;
    run_op("bp_next", 128'd100, 128'd1, 1'b0, 1'b0, 128'd101, 1'b0, 1'b0);

    // Reset in the middle of RUN.
    send(128'h11111111_11111111_11111111_11111111, 128'h22222222_22222222_22222222_22222222,
         1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  W'(in_ready),  W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_sum",       out_sum,       '0);
    check("abort_busy",      W'(busy),      W'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 128'd2, 128'd2, 1'b0, 1'b0, 128'd4, 1'b0, 1'b0);

    // Back-to-back with in_valid held and operands changed right after the first accept.
    send(128'd10, 128'd20, 1'b0, 1'b0, 1'b1);
    in_a = 128'd100; in_b = 128'd7; in_sub = 1'b1; in_cin = 1'b0;
    t1 = -1; t2 = -1;
    for (int e = 1; e < 40; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (t1 < 0) begin
          t1 = e;
          check("b2b_first", out_sum, 128'd30);
        end else if (t2 < 0) begin
          t2 = e;
          check("b2b_second", out_sum, 128'd93);
          check("b2b_second_cout", W'(out_cout), W'(1));
        end
      end
      if (t1 >= 0 && !out_valid && !in_ready && in_valid) in_valid = 1'b0;
      if (t2 >= 0) break;
    end
    if (t2 < 0) timeout("b2b_second");
    else check("b2b_spacing", W'(t2 - t1), W'(NWORDS + 2));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
